// File: rtl/chart_scheduler_if.sv
// rtl/chart_scheduler_if.sv - chart/frame inputs and spawn/status outputs of the chart scheduler
interface chart_scheduler_if #(
  parameter int TW    = 4,
  parameter int LANES = 4,
  parameter int SCW   = 16,
  parameter int DCW   = 8
) ();
  logic             frame_i;
  logic             start_i;
  logic             pause_i;
  logic [LANES-1:0] chart_arrows_i;
  logic [TW-1:0]    chart_timing_i;
  logic [LANES-1:0] lane_full_i;
  logic             chart_next_o;
  logic [LANES-1:0] spawn_o;
  logic             busy_o;
  logic             done_o;
  logic [SCW-1:0]   spawn_cnt_o;
  logic [DCW-1:0]   drop_cnt_o;

  modport master (
    output frame_i, start_i, pause_i, chart_arrows_i, chart_timing_i, lane_full_i,
    input  chart_next_o, spawn_o, busy_o, done_o, spawn_cnt_o, drop_cnt_o
  );

  modport slave (
    input  frame_i, start_i, pause_i, chart_arrows_i, chart_timing_i, lane_full_i,
    output chart_next_o, spawn_o, busy_o, done_o, spawn_cnt_o, drop_cnt_o
  );
endinterface

// File: rtl/chart_scheduler.sv
// rtl/chart_scheduler.sv - steps through chart rows, waits frames, spawns arrows per lane
module chart_scheduler #(
  parameter int TW    = 4,
  parameter int LANES = 4,
  parameter int SCW   = 16,
  parameter int DCW   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  chart_scheduler_if.slave bus
);
  localparam int PCW = $clog2(LANES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WAIT,
    S_SPAWN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LANES-1:0] arrows_q;
  logic [TW-1:0]    delay_q;
  logic [SCW-1:0]   spawn_cnt_q;
  logic [DCW-1:0]   drop_cnt_q;

  logic             chart_next;
  logic             is_spawn;
  logic             end_row;
  logic             frame_tick;
  logic [LANES-1:0] spawn_mask;
  logic [LANES-1:0] drop_mask;
  logic [PCW-1:0]   spawn_pop;
  logic [PCW-1:0]   drop_pop;
  logic [SCW:0]     spawn_sum;
  logic [DCW:0]     drop_sum;

  function automatic logic [PCW-1:0] popcount(input logic [LANES-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + PCW'(v[i]);
    end
    return n;
  endfunction

  // An all-zero row (no arrows, no delay) marks the end of the chart
  assign end_row    = (bus.chart_arrows_i == '0) && (bus.chart_timing_i == '0);
  // Frames only count while waiting, unpaused, and with delay left to burn
  assign frame_tick = (state_q == S_WAIT) && !bus.pause_i && bus.frame_i && (delay_q != '0);

  // Full lanes lose their arrow this row; nothing is carried to a later row
  assign spawn_mask = is_spawn ? (arrows_q & ~bus.lane_full_i) : '0;
  assign drop_mask  = is_spawn ? (arrows_q & bus.lane_full_i) : '0;
  assign spawn_pop  = popcount(spawn_mask);
  assign drop_pop   = popcount(drop_mask);
  assign spawn_sum  = {1'b0, spawn_cnt_q} + (SCW+1)'(spawn_pop);
  assign drop_sum   = {1'b0, drop_cnt_q} + (DCW+1)'(drop_pop);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and single-cycle strobes
  always_comb begin
    state_d    = state_q;
    chart_next = 1'b0;
    is_spawn   = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.start_i) state_d = S_FETCH;
      S_FETCH: begin
        chart_next = 1'b1;
        state_d    = S_LATCH;
      end
      S_LATCH: state_d = end_row ? S_DONE : S_WAIT;
      S_WAIT:  if (!bus.pause_i && (delay_q == '0)) state_d = S_SPAWN;
      S_SPAWN: begin
        is_spawn = 1'b1;
        state_d  = S_FETCH;
      end
      S_DONE:  if (bus.start_i) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Row latch, frame delay countdown and saturating spawn/drop tallies
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arrows_q    <= '0;
      delay_q     <= '0;
      spawn_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (state_q == S_LATCH) begin
        arrows_q <= bus.chart_arrows_i;
        delay_q  <= bus.chart_timing_i;
      end else if (frame_tick) begin
        delay_q <= delay_q - TW'(1);
      end
      if (is_spawn) begin
        spawn_cnt_q <= spawn_sum[SCW] ? '1 : spawn_sum[SCW-1:0];
        drop_cnt_q  <= drop_sum[DCW] ? '1 : drop_sum[DCW-1:0];
      end
    end
  end

  assign bus.chart_next_o = chart_next;
  assign bus.spawn_o      = spawn_mask;
  assign bus.busy_o       = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                            (state_q == S_WAIT)  || (state_q == S_SPAWN);
  assign bus.done_o       = (state_q == S_DONE);
  assign bus.spawn_cnt_o  = spawn_cnt_q;
  assign bus.drop_cnt_o   = drop_cnt_q;
endmodule

// File: tb/tb_chart_scheduler.sv
// tb/tb_chart_scheduler.sv - scoreboard bench for chart_scheduler with random frames/pause
module tb_chart_scheduler;
  localparam int TW = 4, LANES = 4, SCW = 16, DCW = 8;
  localparam int HMAX = 65536;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;

  chart_scheduler_if #(.TW(TW), .LANES(LANES), .SCW(SCW), .DCW(DCW)) bus ();

  chart_scheduler #(.TW(TW), .LANES(LANES), .SCW(SCW), .DCW(DCW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] arrows;
    logic [3:0] timing;
    logic [3:0] lf;
  } row_t;

  typedef struct {
    row_t       row;
    int         fcyc;
    logic [3:0] mask;
    int         spawn_cnt;
    int         drop_cnt;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   frame_hist [HMAX];
  bit   pause_hist [HMAX];
  row_t chart_q [$];
  exp_t exp_q [$];
  int   m_spawn = 0;
  int   m_drop = 0;
  int   end_fcyc = -1;
  bit   gen_en = 0;
  bit   finished = 0;
  logic [3:0] acc_mask = '0;
  int   strobe_n = 0;
  int   strobe_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary();
    if (!finished) begin
      finished = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  endtask

  // Expected spawn cycle from the recorded frame/pause history, straight from the row rules
  function automatic int spawn_cycle(input int fcyc, input int timing);
    int n = timing;
    for (int c = fcyc + 2; c < cyc && c < HMAX; c++) begin
      if (!pause_hist[c]) begin
        if (n == 0) return c + 1;
        if (frame_hist[c]) n--;
      end
    end
    return -1;
  endfunction

  task automatic check_row(input exp_t e);
    int sc;
    sc = spawn_cycle(e.fcyc, int'(e.row.timing));
    check("next_fetch_cycle", cyc, sc + 1);
    check("spawn_mask", {28'd0, acc_mask}, {28'd0, e.mask});
    check("strobe_count", strobe_n, (e.mask != 0) ? 1 : 0);
    if (e.mask != 0) check("spawn_cycle", strobe_cyc, sc);
    check("spawn_cnt", {16'd0, bus.spawn_cnt_o}, e.spawn_cnt);
    check("drop_cnt", {24'd0, bus.drop_cnt_o}, e.drop_cnt);
    acc_mask = '0;
    strobe_n = 0;
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Chart source: presents the next row after each chart_next_o and queues its expectation
  initial forever begin
    row_t r;
    exp_t e;
    @(posedge clk_i);
    #1;
    if (rst_ni && bus.chart_next_o === 1'b1) begin
      if (chart_q.size() > 0) r = chart_q.pop_front();
      else r = '{arrows: 4'd0, timing: 4'd0, lf: 4'd0};
      bus.chart_arrows_i = r.arrows;
      bus.chart_timing_i = r.timing;
      bus.lane_full_i    = r.lf;
      if (r.arrows == 0 && r.timing == 0) begin
        end_fcyc = cyc;
      end else begin
        m_spawn = m_spawn + $countones(r.arrows & ~r.lf);
        if (m_spawn > 65535) m_spawn = 65535;
        m_drop = m_drop + $countones(r.arrows & r.lf);
        if (m_drop > 255) m_drop = 255;
        e.row = r;
        e.fcyc = cyc;
        e.mask = r.arrows & ~r.lf;
        e.spawn_cnt = m_spawn;
        e.drop_cnt = m_drop;
        exp_q.push_back(e);
      end
    end
  end

  // Frame pulses at random spacing and bursty pause
  initial begin
    int gap = 2;
    bus.frame_i = 1'b0;
    bus.pause_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (gen_en) begin
        if (gap == 0) begin
          bus.frame_i = 1'b1;
          gap = $urandom_range(3, 10);
        end else begin
          bus.frame_i = 1'b0;
          gap--;
        end
        if (bus.pause_i) begin
          if ($urandom_range(0, 3) == 0) bus.pause_i = 1'b0;
        end else if ($urandom_range(0, 11) == 0) begin
          bus.pause_i = 1'b1;
        end
      end else begin
        bus.frame_i = 1'b0;
        bus.pause_i = 1'b0;
      end
    end
  end

  // Monitor: records history and spawn strobes, checks each row when the next fetch appears
  initial forever begin
    @(negedge clk_i);
    if (cyc < HMAX) begin
      frame_hist[cyc] = bus.frame_i;
      pause_hist[cyc] = bus.pause_i;
    end
    if (bus.spawn_o !== 4'd0) begin
      acc_mask |= bus.spawn_o;
      strobe_n++;
      strobe_cyc = cyc;
    end
    if (bus.chart_next_o === 1'b1 && exp_q.size() > 0 && exp_q[0].fcyc < cyc)
      check_row(exp_q.pop_front());
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    errors++;
    summary();
  end

  task automatic pulse_start();
    @(posedge clk_i);
    #1 bus.start_i = 1'b1;
    @(posedge clk_i);
    #1 bus.start_i = 1'b0;
    check("chart_next_after_start", bus.chart_next_o, 1);
  endtask

  task automatic run_segment();
    int t = 0;
    pulse_start();
    while (t < 20000) begin
      @(posedge clk_i);
      #1 bus.start_i = 1'b0;
      if (bus.done_o === 1'b1) break;
      bus.start_i = ($urandom_range(0, 7) == 0);
      t++;
    end
    check("done_reached", (t < 20000) ? 1 : 0, 1);
    check("done_cycle", cyc, end_fcyc + 2);
    check("done_o", bus.done_o, 1);
    check("busy_in_done", bus.busy_o, 0);
    check("rows_all_checked", exp_q.size(), 0);
    check("spawn_cnt_done", {16'd0, bus.spawn_cnt_o}, m_spawn);
    check("drop_cnt_done", {24'd0, bus.drop_cnt_o}, m_drop);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"}, bus.busy_o, 0);
    check({name, "_done"}, bus.done_o, 0);
    check({name, "_chart_next"}, bus.chart_next_o, 0);
    check({name, "_spawn"}, {28'd0, bus.spawn_o}, 0);
    check({name, "_spawn_cnt"}, {16'd0, bus.spawn_cnt_o}, 0);
    check({name, "_drop_cnt"}, {24'd0, bus.drop_cnt_o}, 0);
  endtask

  initial begin
    row_t r;
    bus.start_i = 1'b0;
    bus.chart_arrows_i = '0;
    bus.chart_timing_i = '0;
    bus.lane_full_i = '0;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 check_quiet("reset");
    rst_ni = 1'b1;
    gen_en = 1;
    repeat (4) @(posedge clk_i);
    #1 check_quiet("idle_hold");

    // Directed rows: plain spawn, frame delay, partial full lanes, short delay, end
    chart_q.push_back('{arrows: 4'b0101, timing: 4'd0, lf: 4'b0000});
    chart_q.push_back('{arrows: 4'b1000, timing: 4'd3, lf: 4'b0000});
    chart_q.push_back('{arrows: 4'b1111, timing: 4'd0, lf: 4'b0110});
    chart_q.push_back('{arrows: 4'b0010, timing: 4'd2, lf: 4'b0000});
    chart_q.push_back('{arrows: 4'b0000, timing: 4'd0, lf: 4'b0000});
    run_segment();

    // Drop counter driven to 254 then past all-ones; restart from DONE keeps counts
    for (int i = 0; i < 63; i++) chart_q.push_back('{arrows: 4'b1111, timing: 4'd0, lf: 4'b1111});
    chart_q.push_back('{arrows: 4'b0011, timing: 4'd0, lf: 4'b1111});
    chart_q.push_back('{arrows: 4'b1111, timing: 4'd0, lf: 4'b1111});
    chart_q.push_back('{arrows: 4'b0101, timing: 4'd0, lf: 4'b1111});
    chart_q.push_back('{arrows: 4'b0000, timing: 4'd0, lf: 4'b0000});
    run_segment();
    check("drop_saturated", {24'd0, bus.drop_cnt_o}, 255);

    // Random rows
    for (int i = 0; i < 25; i++) begin
      r.arrows = 4'($urandom_range(0, 15));
      r.timing = 4'($urandom_range(0, 3));
      r.lf     = 4'($urandom_range(0, 15));
      if (r.arrows == 0 && r.timing == 0) r.arrows = 4'b0001;
      chart_q.push_back(r);
    end
    chart_q.push_back('{arrows: 4'b0000, timing: 4'd0, lf: 4'b0000});
    run_segment();

    // Reset in the middle of a waiting row
    chart_q.push_back('{arrows: 4'b1000, timing: 4'd3, lf: 4'b0000});
    pulse_start();
    repeat (3) @(posedge clk_i);
    #1 check("busy_before_reset", bus.busy_o, 1);
    #2 rst_ni = 1'b0;
    #1 check_quiet("async_reset");
    exp_q.delete();
    chart_q.delete();
    acc_mask = '0;
    strobe_n = 0;
    m_spawn = 0;
    m_drop = 0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    #1 check_quiet("post_reset_idle");

    summary();
  end
endmodule

// File: doc/chart_scheduler.md
CHART_SCHEDULER -- requirements
Module: chart_scheduler

Interface
REQ-001 Parameter: TW, default 4, width of the chart timing field and of the internal frame-delay counter.
REQ-002 Parameter: LANES, default 4, number of arrow lanes (left, up, down, right, bit 0 = left).
REQ-003 Parameter: SCW, default 16, width of the spawned-arrow counter.
REQ-004 Parameter: DCW, default 8, width of the dropped-arrow counter.
REQ-005 clk_i  in  1  single clock (pixel clock domain); all state changes on its rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 frame_i  in  1  one-cycle pulse at the start of vertical blanking.
REQ-008 start_i  in  1  begin chart playback.
REQ-009 pause_i  in  1  level; freezes frame counting.
REQ-010 chart_arrows_i  in  LANES  lane mask of the current chart row.
REQ-011 chart_timing_i  in  TW  frames to wait before the current row spawns.
REQ-012 lane_full_i  in  LANES  per lane: all arrow slots occupied.
REQ-013 chart_next_o  out  1  one-cycle request to advance the chart row.
REQ-014 spawn_o  out  LANES  one-cycle per-lane spawn strobe.
REQ-015 busy_o  out  1  high in FETCH, LATCH, WAIT and SPAWN.
REQ-016 done_o  out  1  high in DONE.
REQ-017 spawn_cnt_o  out  SCW  total arrows spawned, saturating.
REQ-018 drop_cnt_o  out  DCW  total arrows dropped due to full lanes, saturating.

Function
REQ-019 The FSM SHALL have the states IDLE, FETCH, LATCH, WAIT, SPAWN and DONE.
REQ-020 IDLE SHALL go to FETCH on start_i; otherwise it SHALL hold.
REQ-021 FETCH SHALL assert chart_next_o for exactly its one cycle and then go to LATCH.
REQ-022 LATCH SHALL register chart_arrows_i into arrows_q and chart_timing_i into the delay counter; the chart row is valid one cycle after chart_next_o.
REQ-023 In LATCH, a row with arrows==0 and timing==0 is the end-of-chart marker and SHALL go to DONE; any other row SHALL go to WAIT.
REQ-024 In WAIT with pause_i low:
- counter==0 SHALL go to SPAWN.
- otherwise frame_i SHALL decrement the counter by 1.
REQ-025 In WAIT with pause_i high, the block SHALL neither count nor transition; frame_i is ignored.
REQ-026 Pause SHALL NOT stall FETCH, LATCH or SPAWN.
REQ-027 SPAWN SHALL last one cycle, drive spawn_o = arrows_q & ~lane_full_i combinationally, then go to FETCH.
REQ-028 spawn_o SHALL be 0 in every state other than SPAWN.
REQ-029 Lanes with arrows_q & lane_full_i SHALL be dropped, never deferred.
REQ-030 In SPAWN, spawn_cnt_o SHALL add popcount(spawn_o) and drop_cnt_o SHALL add popcount(arrows_q & lane_full_i).
REQ-031 Both counters SHALL saturate at all-ones and never wrap.
REQ-032 DONE SHALL go to FETCH on start_i and SHALL NOT clear the counters.
REQ-033 start_i SHALL be ignored in FETCH, LATCH, WAIT and SPAWN.
REQ-034 Timing for a row with timing=0 and start_i at cycle 0:
- FETCH at cycle 1.
- LATCH at cycle 2.
- WAIT at cycle 3.
- SPAWN at cycle 4, then FETCH at cycle 5.
REQ-035 A row with timing=N>0 SHALL spawn on the cycle after WAIT observes the N-th unpaused frame_i, plus one cycle.

Reset
REQ-036 rst_ni low SHALL immediately force:
- state to IDLE.
- chart_next_o, spawn_o, busy_o and done_o to 0.
- arrows_q, the delay counter, spawn_cnt_o and drop_cnt_o to 0.
REQ-037 Reset asserted mid-WAIT or mid-SPAWN SHALL abort the row with no spawn strobe or count update; after release, the block waits in IDLE for start_i.

Verification
REQ-038 Start with row {arrows=4'b0101, timing=0}, lanes not full -> chart_next_o at cycle 1, spawn_o=4'b0101 at cycle 4, spawn_cnt_o=2.
REQ-039 Row {arrows=4'b1000, timing=3}, frame_i every 10 cycles -> no spawn before the third frame_i in WAIT; spawn_o=4'b1000 two cycles after it.
REQ-040 Row {arrows=4'b1111, timing=0} with lane_full_i=4'b0110 -> spawn_o=4'b1001, spawn_cnt_o +2, drop_cnt_o +2.
REQ-041 timing=2 with pause_i high across two frame_i pulses, then released -> the counter holds at 2; spawn occurs only after two further unpaused frames.
REQ-042 End-of-chart row {0,0} -> done_o=1, busy_o=0; start_i -> chart_next_o next cycle, counters retained.
REQ-043 drop_cnt_o preloaded to 8'hFE, row 4'b1111 with all lanes full -> drop_cnt_o=8'hFF; rst_ni pulsed in WAIT -> all outputs 0, state IDLE.
